bit_serializer: RTL
===================

# bit_serializer

Parallel-to-bit-serial transmitter for the bit-serial SHA-256 datapath. Accepts W-bit words over a valid/ready handshake and generates the `bclk` bit strobe, the `counter` bit index and the serial `out` stream that the bit-serial operator modules consume. Those modules sample `in` on the `bclk` rising edge, so this block changes `out` and `counter` only on `bclk` falling edges. It sits at the head of every serial word lane, fed by the message-schedule and constant loaders.

## Interface
- `W`, default 32: word width in bits; W ≥ 2.
- `HALF`, default 2: clk cycles per `bclk` half-period; HALF ≥ 1.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: word offered.
- `in_ready`  out  1: word accepted when `in_valid && in_ready` at a clk edge.
- `in_data`  in  W: word to serialize.
- `bclk`  out  1: bit strobe. Low for HALF cycles, then high for HALF cycles, per bit.
- `counter`  out  $clog2(W): index of the bit currently on `out`.
- `out`  out  1: serial data bit.
- `busy`  out  1: a word is being streamed.
- `word_done`  out  1: one-cycle pulse at the end of the last bit of a word.

## Operation
- One-entry holding register `hold`/`hold_valid`. `in_ready = !hold_valid`. A word can be accepted in any state.
- Shift register `sreg` (W bits) plus a half-period timer `tmr` (0..HALF-1).
- FSM states: IDLE, BIT_LO, BIT_HI.
- **IDLE**:
  - Outputs: `bclk`=0, `out`=0, `counter`=0, `busy`=0.
  - If `hold_valid`: load `sreg` from `hold`, clear `hold_valid`, drive `out` = first bit, set `counter`=0, `busy`=1, `tmr`=0, go to BIT_LO.
- **BIT_LO**: `bclk`=0. When `tmr`==HALF-1, set `bclk`=1, `tmr`=0, go to BIT_HI. Otherwise `tmr`++.
- **BIT_HI**: `bclk`=1. When `tmr`==HALF-1, drop `bclk` to 0 and take one of three paths:
  - `counter` < W-1: shift `sreg`, put the next bit on `out`, `counter`++, go to BIT_LO.
  - `counter` == W-1 and `hold_valid`: pulse `word_done`, load the next word exactly as IDLE does, go to BIT_LO. There is no gap between words.
  - `counter` == W-1 and no held word: pulse `word_done`, set `out`=0, `counter`=0, `busy`=0, go to IDLE.
- Bit order (default): LSB first. Bit k of the word is on `out` while `counter`==k.
- A word that arrives in the same cycle that `hold` is consumed is not accepted, because `in_ready` is a registered-state function. It is accepted on the next cycle.
- Reset mid-word: the word in flight and the held word are discarded, with no `word_done` pulse.

## Timing
- Reset values: `bclk`=0, `out`=0, `counter`=0, `busy`=0, `word_done`=0, `in_ready`=1, state IDLE.
- Latency from IDLE: handshake at edge E0 → `hold_valid` after E0 → at E1 `busy`=1 and bit 0 on `out` → first `bclk` rise at E1+HALF.
- Bit period is 2·HALF cycles. Word period is 2·HALF·W cycles.
- `out` and `counter` change only on the same edge that `bclk` goes 1→0, or on the IDLE load edge. They are stable for HALF cycles before and HALF cycles after each `bclk` rise.
- `word_done` is high for exactly the one cycle after the edge where the last bit's high phase ends.

## Configuration
- `BIT_SERIALIZER_MSB_FIRST_EN`:
  - Defined: bit W-1-k is on `out` while `counter`==k (MSB first), and `sreg` shifts left.
  - Undefined: LSB first, and `sreg` shifts right.
- `counter`, handshake and timing are identical in both builds.

## Structure
- Shared package `bitser_pkg` holds:
  - the `bitser_state_t` enum {IDLE, BIT_LO, BIT_HI};
  - the localparam default word width 32.
- One sub-module, `bclk_timer`. It holds the HALF-cycle half-period counter and asserts `half_end` when `tmr`==HALF-1, with the restart controlled by the FSM.

## Test plan
All scenarios use W=8, HALF=2 unless noted.
- Reset, then idle for 20 cycles → `in_ready`=1; `bclk`, `out`, `counter`, `busy`, `word_done` all stay 0.
- Single word 0xA5 → `out` sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles with `counter` 0..7; `word_done` pulses once 32 cycles after `busy` rises; then IDLE.
- Words 0x01 and 0x80 offered back-to-back → 16 contiguous bit periods with no IDLE cycle; `out` is 1 only at word 0 `counter` 0 and at word 1 `counter` 7; two `word_done` pulses 32 cycles apart.
- `in_valid` held high with 3 words → `in_ready` drops after the 2nd is accepted; the 3rd is accepted only after the 1st word completes; all 24 bits arrive in order.
- `rst_n` asserted during bit 3 of 0xFF → all outputs return to 0 immediately; no `word_done`; the next word 0x0F streams correctly from `counter` 0.
- Build with `BIT_SERIALIZER_MSB_FIRST_EN`, word 0xA5 → `out` sequence 1,0,1,0,0,1,0,1 (symmetric check), then word 0x01 → `out` is 1 only at `counter` 7.

Source files
------------

// File: rtl/bitser_pkg.sv
// Shared types and defaults for the bit-serial word transmitter.
package bitser_pkg;

  localparam int BITSER_DEFAULT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_LO = 2'd1,
    BIT_HI = 2'd2
  } bitser_state_t;

endpackage

// File: rtl/bit_serializer_bclk_timer.sv
// Half-period timer for the bclk strobe; half_end_o flags the last cycle of a half-period.
module bclk_timer #(
  parameter int HALF = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic half_end_o
);

  localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;

  assign half_end_o = (tmr_q == TW'(HALF - 1));

  // Wraps at the end of every half-period and is held at zero while the FSM idles.
  always_comb begin
    tmr_d = tmr_q + TW'(1);
    if (clear_i || half_end_o) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-bit-serial transmitter producing bclk, bit index and serial data.
// Define BIT_SERIALIZER_MSB_FIRST_EN for MSB-first order (default LSB first).
module bit_serializer
  import bitser_pkg::*;
#(
  parameter int W    = BITSER_DEFAULT_W,
  parameter int HALF = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [W-1:0]         in_data_i,
  output logic                 bclk_o,
  output logic [$clog2(W)-1:0] counter_o,
  output logic                 out_o,
  output logic                 busy_o,
  output logic                 word_done_o
);

  localparam int CW = $clog2(W);

  bitser_state_t state_q, state_d;

  logic [W-1:0]  hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic          out_q, out_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          word_done_q, word_done_d;

  logic halfEnd;
  logic lastBit;
  logic bitEnd;
  logic loadWord;
  logic shiftBit;
  logic accept;

  bclk_timer #(
    .HALF (HALF)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (state_q == IDLE),
    .half_end_o (halfEnd)
  );

  assign lastBit  = (counter_q == CW'(W - 1));
  assign bitEnd   = (state_q == BIT_HI) && halfEnd;
  assign loadWord = hold_valid_q && ((state_q == IDLE) || (bitEnd && lastBit));
  assign shiftBit = bitEnd && !lastBit;
  assign accept   = in_valid_i && !hold_valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hold_valid_q) state_d = BIT_LO;
      BIT_LO:  if (halfEnd) state_d = BIT_HI;
      BIT_HI: begin
        if (halfEnd) begin
          state_d = (lastBit && !hold_valid_q) ? IDLE : BIT_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bclk_o      = (state_q == BIT_HI);
    busy_o      = (state_q != IDLE);
    in_ready_o  = !hold_valid_q;
    out_o       = out_q;
    counter_o   = counter_q;
    word_done_o = word_done_q;
  end

  // A new word is loaded either from IDLE or seamlessly on the last bit's falling bclk edge.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    sreg_d       = sreg_q;
    out_d        = out_q;
    counter_d    = counter_q;
    word_done_d  = bitEnd && lastBit;

    if (loadWord) begin
      sreg_d       = hold_q;
      counter_d    = '0;
      hold_valid_d = 1'b0;
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
      out_d        = hold_q[W-1];
`else
      out_d        = hold_q[0];
`endif
    end else if (shiftBit) begin
      counter_d = counter_q + CW'(1);
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
      sreg_d    = sreg_q << 1;
      out_d     = sreg_q[W-2];
`else
      sreg_d    = sreg_q >> 1;
      out_d     = sreg_q[1];
`endif
    end else if (bitEnd && lastBit) begin
      out_d     = 1'b0;
      counter_d = '0;
    end

    if (accept) begin
      hold_d       = in_data_i;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      sreg_q       <= '0;
      out_q        <= 1'b0;
      counter_q    <= '0;
      word_done_q  <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sreg_q       <= sreg_d;
      out_q        <= out_d;
      counter_q    <= counter_d;
      word_done_q  <= word_done_d;
    end
  end

endmodule
